// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter sizing for the serial adder
package serial_adder_pkg;
  localparam int WIDTH_MAX = 32;
  localparam int CNT_W = $clog2(WIDTH_MAX);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/fa_nand.sv
// fa_nand: 1-bit full adder built from nine 2-input NAND gates
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic n1, n2, n3, x1, n4, n5, n6;
  nand g1 (n1, a, b);
  nand g2 (n2, a, n1);
  nand g3 (n3, b, n1);
  nand g4 (x1, n2, n3);
  nand g5 (n4, x1, cin);
  nand g6 (n5, x1, n4);
  nand g7 (n6, cin, n4);
  nand g8 (sum, n5, n6);
  nand g9 (cout, n1, n4);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with start/busy/done handshake
// Optional signed overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_q, res_d, sum_q;
  logic               c_q, busy_q, done_q, cout_q, fa_s, fa_c, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q;
  assign ovf = ovf_q;
`endif
  fa_nand u_fa (.a(a_sh_q[0]), .b(b_sh_q[0]), .cin(c_q), .sum(fa_s), .cout(fa_c));
  assign res_d = {fa_s, res_q[WIDTH-1:1]};
  assign last  = (cnt_q == CNT_W'(WIDTH - 1));
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_d;
          c_q    <= fa_c;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q is the carry into the MSB during the last bit
            ovf_q   <= c_q ^ fa_c;
`endif
          end
        end
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_sh_q  <= a;
            b_sh_q  <= b;
            c_q     <= cin;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4
module tb_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st8 = 0, cin8 = 0, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic st4 = 0, cin4 = 0, busy4, done4, cout4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf4;
`endif
  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );
  typedef struct {logic [7:0] s; logic c; logic v;} exp_t;
  exp_t exp8[$], exp4[$];
  int vec = 0, bad = 0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, got, want);
    end
  endtask
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t e;
    int u, sa, sb, sv;
    u = int'(a) + int'(b) + int'(c);
    e.s = 8'(u & ((1 << w) - 1));
    e.c = 1'((u >> w) & 1);
    sa = int'(a) - ((((int'(a) >> (w - 1)) & 1) != 0) ? (1 << w) : 0);
    sb = int'(b) - ((((int'(b) >> (w - 1)) & 1) != 0) ? (1 << w) : 0);
    sv = sa + sb + int'(c);
    e.v = (sv > (1 << (w - 1)) - 1) || (sv < -(1 << (w - 1)));
    return e;
  endfunction
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && done8) begin
      if (exp8.size() == 0) begin
        vec++; bad++;
        $display("FAIL done8: got unexpected done expected none");
      end else begin
        e = exp8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.s));
        chk("cout8", 32'(cout8), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", 32'(ovf8), 32'(e.v));
`endif
      end
    end
  end
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && done4) begin
      if (exp4.size() == 0) begin
        vec++; bad++;
        $display("FAIL done4: got unexpected done expected none");
      end else begin
        e = exp4.pop_front();
        chk("sum4", 32'(sum4), 32'(e.s));
        chk("cout4", 32'(cout4), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf4", 32'(ovf4), 32'(e.v));
`endif
      end
    end
  end
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; st8 = 1;
    exp8.push_back(model(8, a, b, c));
    @(negedge clk);
    st8 = 0;
  endtask
  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4 = a; b4 = b; cin4 = c; st4 = 1;
    exp4.push_back(model(4, {4'h0, a}, {4'h0, b}, c));
    @(negedge clk);
    st4 = 0;
  endtask
  task automatic wait_done(input int w, output int n);
    n = 0;
    while (!(w == 8 ? done8 : done4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vec++; bad++;
      $display("FAIL timeout%0d: got no done expected done within 40 cycles", w);
    end
  endtask
  initial begin
    int n;
    #1;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_sum8", 32'(sum8), 0);
    chk("rst_cout8", 32'(cout8), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf8", 32'(ovf8), 0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go8(8'h5A, 8'h3C, 0);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("busy8_k%0d", k), 32'(busy8), 32'(k <= 8));
      chk($sformatf("done8_k%0d", k), 32'(done8), 32'(k == 9));
    end
    @(negedge clk);
    chk("done8_pulse", 32'(done8), 0);
    chk("busy8_idle", 32'(busy8), 0);
    go8(8'hFF, 8'h01, 0);
    wait_done(8, n);
    chk("lat_ff01", n, 8);
    @(negedge clk);
    go8(8'h00, 8'h00, 1);
    wait_done(8, n);
    @(negedge clk);
    go8(8'h01, 8'h02, 0);
    @(negedge clk); @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; st8 = 1;
    @(negedge clk);
    st8 = 0;
    wait_done(8, n);
    chk("lat_ignored", n, 5);
    repeat (12) @(negedge clk);
    go8(8'h12, 8'h34, 0);
    wait_done(8, n);
    go8(8'h80, 8'h80, 0);
    chk("b2b_busy", 32'(busy8), 1);
    chk("b2b_done", 32'(done8), 0);
    wait_done(8, n);
    chk("b2b_lat", n, 8);
    @(negedge clk);
    go8(8'h01, 8'h01, 1);
    wait_done(8, n);
    @(negedge clk);
    go8(8'h21, 8'h43, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_busy8", 32'(busy8), 0);
    chk("arst_done8", 32'(done8), 0);
    chk("arst_sum8", 32'(sum8), 0);
    chk("arst_cout8", 32'(cout8), 0);
    exp8.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("arst_no_done", 32'(exp8.size()), 0);
    go8(8'h21, 8'h43, 0);
    wait_done(8, n);
    @(negedge clk);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          go4(4'(a), 4'(b), 1'(c));
          wait_done(4, n);
        end
    repeat (3) @(negedge clk);
    chk("pending8", 32'(exp8.size()), 0);
    chk("pending4", 32'(exp4.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
